fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage sitting directly upstream of the decoder. Generates sequential 32-bit PCs, issues requests to a variable-latency instruction memory through a request/grant port, and buffers returned instructions in a small FIFO. Presents instructions with their PCs to decode over a valid/ready handshake. A branch-taken redirect flushes the buffer and squashes stale in-flight responses.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: maximum granted-but-unreturned requests, 1..DEPTH.

- `clk` in 1: the single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: request valid.
- `imem_addr` out 32: word-aligned fetch address; bits [1:0] always 0.
- `imem_gnt` in 1: request accepted this cycle when `imem_req` is high.
- `imem_rvalid` in 1: response valid; responses return in order, ≥1 cycle after grant.
- `imem_rdata` in 32: instruction word.
- `redirect_valid` in 1: branch/jump taken; one-cycle pulse.
- `redirect_pc` in 32: new fetch target; bits [1:0] ignored and forced to 0.
- `halt` in 1: level; while high, no new requests are issued.
- `ins_valid` out 1: `ins`/`ins_pc` valid.
- `ins_ready` in 1: decode accepts.
- `ins` out 32: instruction at FIFO head.
- `ins_pc` out 32: PC of `ins`.
- `stat_fetched` out 32, `stat_squashed` out 32: only with `FETCH_STATS_EN`.

## Operation
- State: `fetch_pc`, `outstanding` count, `squash_cnt`, FIFO of {pc, ins}, and 2-state FSM RUN/STOP.
- RUN→STOP when `halt`=1; STOP→RUN when `halt`=0. In STOP, `imem_req`=0; in-flight responses are still accepted.
- `imem_req` = RUN && `fifo_count + (outstanding − squash_cnt) < DEPTH` && `outstanding < MAX_OUTSTANDING`.
- On `imem_req && imem_gnt`, the PC is recorded in the in-flight PC queue, `fetch_pc += 4` with 32-bit wrap (0xFFFF_FFFC→0), and `outstanding++`.
- While `imem_req && !imem_gnt`, `imem_addr` is held stable. No request is dropped or duplicated.
- On `imem_rvalid`, `outstanding--`. If `squash_cnt>0`, the response is discarded and `squash_cnt--`; otherwise it is pushed to the FIFO with its PC.
- `imem_rvalid` with `outstanding==0` is ignored.
- Pop on `ins_valid && ins_ready`.
- Redirect has priority over all other events in its cycle:
  - FIFO is flushed.
  - `fetch_pc <= redirect_pc & ~3`.
  - `squash_cnt <= outstanding + (imem_req&&imem_gnt) − imem_rvalid`. A grant in the redirect cycle is therefore squashed, and any response arriving in that cycle is discarded.
- `ins_valid = !fifo_empty && !redirect_valid`, so no handshake completes in a redirect cycle.
- Simultaneous push and pop on a full FIFO is allowed; count is unchanged.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `ins_valid`=0, `ins`=0, `ins_pc`=0. FIFO empty, counters 0, FSM=RUN.
- First cycle after reset release: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Minimum latency:
  - grant in cycle N, `rvalid` in N+1, `ins_valid` in N+2.
  - Throughput is 1 instruction/cycle with `MAX_OUTSTANDING`≥2 and single-cycle memory.
- After redirect in cycle R: first request to the target in R+1; earliest `ins_valid` for the target in R+3.
- Reset mid-operation clears everything asynchronously. Stale responses after reset are dropped by the `outstanding==0` rule.

## Configuration
- `FETCH_STATS_EN` defined:
  - `stat_fetched` increments per FIFO push.
  - `stat_squashed` increments per discarded response (squash, or `outstanding==0`).
  - Both wrap at 2^32 and reset to 0.
- `FETCH_STATS_EN` undefined: stat ports and counters are absent. Fetch behaviour is identical.

## Structure
- The shared define header carries `ENABLE`/`DISABLE`, the FSM encodings `FETCH_RUN`/`FETCH_STOP`, and the instruction-width constant 32.
- One sub-module: `fetch_fifo`.
  - Parameterised by `DEPTH` and width 64.
  - Provides push, pop, flush, count, full and empty.
  - Flush has priority over push.
- The in-flight PC queue is a `MAX_OUTSTANDING`-entry instance of the same `fetch_fifo`. It is never flushed, because squashed entries are popped as their responses return.

## Test plan
- Reset release, `gnt`=1, 1-cycle memory, `rdata`=addr^32'hA5A5_A5A5, `ins_ready`=1 → `ins_pc` 0,4,8,… on consecutive cycles; first `ins_valid` 2 cycles after the first grant.
- `ins_ready`=0 → exactly 4 entries buffered, then `imem_req` drops with no overflow; raise `ready` → `ins_pc` order 0x0,0x4,0x8,0xC,0x10.
- Redirect to 0x103 with 2 outstanding → both stale responses discarded; next `ins_pc`=0x100; `stat_squashed`=2.
- `imem_gnt` low 3 cycles at addr 0x8 → `imem_addr` stays 0x8; exactly one 0x8 instruction delivered.
- Assert `halt` after grant of 0xC → no further `req`; 0xC still delivered; deassert → next request at 0x10.
- `rst_n` low mid-stream with 2 outstanding, then stray `rvalid` after release → ignored; first `ins_pc`=`RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and types for the fetch stage
//
// Purpose : enable/disable levels, instruction width, run/stop FSM encoding
//           and a word-alignment helper used by fetch_unit and its interface.
// Ports   : none (package).
package fetch_unit_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam int INS_W = 32;

   typedef enum logic {
      FETCH_RUN  = 1'b0,
      FETCH_STOP = 1'b1
   } fetch_state_e;

   // Clears the byte-offset bits so every fetch address is word aligned.
   function automatic logic [INS_W-1:0] align_word(input logic [INS_W-1:0] a);
      return a & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory, redirect and decode-side signals of the fetch stage
//
// Purpose : bundles the request/grant memory port, the redirect/halt controls
//           and the valid/ready instruction output into one interface.
// Modports: master - the fetch unit (drives imem_req/imem_addr, ins_valid/ins/ins_pc)
//           slave  - the environment (memory, branch unit, decoder)
interface fetch_unit_if;
   import fetch_unit_pkg::*;

   logic             imem_req;
   logic [INS_W-1:0] imem_addr;
   logic             imem_gnt;
   logic             imem_rvalid;
   logic [INS_W-1:0] imem_rdata;
   logic             redirect_valid;
   logic [INS_W-1:0] redirect_pc;
   logic             halt;
   logic             ins_valid;
   logic             ins_ready;
   logic [INS_W-1:0] ins;
   logic [INS_W-1:0] ins_pc;

   modport master (
      output imem_req, imem_addr, ins_valid, ins, ins_pc,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, ins_ready
   );

   modport slave (
      input  imem_req, imem_addr, ins_valid, ins, ins_pc,
      output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, halt, ins_ready
   );

endinterface

// File: rtl/fetch_unit_fifo.sv
// rtl/fetch_unit_fifo.sv - synchronous FIFO used for instruction buffering and in-flight PCs
//
// Purpose : DEPTH-entry FIFO (any DEPTH >= 1) with flush; flush beats push.
//           Push on a full FIFO is accepted only together with a pop.
// Ports   : i_clk, i_rst_n (async active-low)
//           i_push/i_wdata, i_pop, i_flush
//           o_rdata (head entry), o_count, o_full, o_empty
module fetch_fifo #(
   parameter  int DEPTH = 4,
   parameter  int WIDTH = 64,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_rdata,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   // Pointers wrap explicitly so non-power-of-two depths work too.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
            r_wr_ptr        <= next_ptr(r_wr_ptr);
         end
         if (w_do_pop) begin
            r_rd_ptr <= next_ptr(r_rd_ptr);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: sequential PCs, request/grant memory port, instruction buffer
//
// Purpose : issues word-aligned fetches to a variable-latency in-order memory,
//           buffers returned words with their PCs and hands them to decode over
//           valid/ready. A redirect flushes the buffer and squashes every
//           response still in flight (including one granted in the same cycle).
// Ports   : i_clk, i_rst_n (async active-low)
//           bus (fetch_unit_if.master): imem_req/addr/gnt, imem_rvalid/rdata,
//              redirect_valid/pc, halt, ins_valid/ready, ins, ins_pc
//           o_stat_fetched, o_stat_squashed - present only with FETCH_STATS_EN
// Options : `define FETCH_STATS_EN adds push/discard counters (wrap at 2^32).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = 32'h0000_0000,
   parameter int          DEPTH           = 4,
   parameter int          MAX_OUTSTANDING = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0] o_stat_fetched,
   output logic [31:0] o_stat_squashed
`endif
);

   localparam int FCNT_W = $clog2(DEPTH + 1);
   localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int OCC_W  = FCNT_W + 1;

   fetch_state_e        r_state;
   fetch_state_e        w_state_nxt;
   logic [INS_W-1:0]    r_fetch_pc;
   logic [OUT_W-1:0]    r_squash_cnt;

   logic [FCNT_W-1:0]   w_fifo_count;
   logic                w_fifo_full;
   logic                w_fifo_empty;
   logic [2*INS_W-1:0]  w_fifo_rdata;
   logic [OUT_W-1:0]    w_outstanding;
   logic                w_pcq_full;
   logic                w_pcq_empty;
   logic [INS_W-1:0]    w_rsp_pc;
   logic [OCC_W-1:0]    w_occupancy;
   logic                w_req;
   logic                w_fire;
   logic                w_rsp;
   logic                w_fifo_push;
   logic                w_ins_valid;
   logic                w_pop;

   // Run/stop FSM: STOP only suppresses new requests; returning data still lands.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= FETCH_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FETCH_RUN:  if (bus.halt)  w_state_nxt = FETCH_STOP;
         FETCH_STOP: if (!bus.halt) w_state_nxt = FETCH_RUN;
         default:    w_state_nxt = FETCH_RUN;
      endcase
   end

   // Buffer slots already promised: stored words plus live (non-squashed)
   // requests. Squashed ones will never be pushed, so they do not reserve space.
   assign w_occupancy = OCC_W'(w_fifo_count) + OCC_W'(w_outstanding - r_squash_cnt);

   // Gating with reset keeps the request low while reset is held.
   assign w_req = i_rst_n && (r_state == FETCH_RUN)
                  && (w_occupancy < OCC_W'(DEPTH)) && !w_pcq_full;
   assign w_fire = w_req && bus.imem_gnt;

   // A response with nothing in flight (e.g. a leftover from before reset) is ignored.
   assign w_rsp = bus.imem_rvalid && !w_pcq_empty;

   assign w_fifo_push = w_rsp && (r_squash_cnt == '0) && !bus.redirect_valid
                        && (!w_fifo_full || w_pop);
   assign w_ins_valid = (!w_fifo_empty && !bus.redirect_valid) ? ENABLE : DISABLE;
   assign w_pop       = w_ins_valid && bus.ins_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_pc   <= align_word(RESET_PC);
         r_squash_cnt <= '0;
      end else if (bus.redirect_valid) begin
         r_fetch_pc   <= align_word(bus.redirect_pc);
         // Everything in flight after this edge belongs to the old path.
         r_squash_cnt <= w_outstanding + OUT_W'(w_fire) - OUT_W'(w_rsp);
      end else begin
         if (w_fire) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_rsp && (r_squash_cnt != '0)) begin
            r_squash_cnt <= r_squash_cnt - OUT_W'(1);
         end
      end
   end

   // In-flight PC queue: its occupancy is the outstanding count. Squashed
   // entries drain naturally as their responses return, so it is never flushed.
   fetch_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (INS_W)
   ) u_pc_queue (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_fire),
      .i_wdata (r_fetch_pc),
      .i_pop   (w_rsp),
      .i_flush (1'b0),
      .o_rdata (w_rsp_pc),
      .o_count (w_outstanding),
      .o_full  (w_pcq_full),
      .o_empty (w_pcq_empty)
   );

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (2 * INS_W)
   ) u_ins_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_fifo_push),
      .i_wdata ({w_rsp_pc, bus.imem_rdata}),
      .i_pop   (w_pop),
      .i_flush (bus.redirect_valid),
      .o_rdata (w_fifo_rdata),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign bus.imem_req  = w_req;
   assign bus.imem_addr = r_fetch_pc;
   assign bus.ins_valid = w_ins_valid;
   assign bus.ins_pc    = w_fifo_rdata[2*INS_W-1:INS_W];
   assign bus.ins       = w_fifo_rdata[INS_W-1:0];

`ifdef FETCH_STATS_EN
   logic [31:0] r_stat_fetched;
   logic [31:0] r_stat_squashed;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stat_fetched  <= '0;
         r_stat_squashed <= '0;
      end else begin
         if (w_fifo_push) begin
            r_stat_fetched <= r_stat_fetched + 32'd1;
         end
         if (bus.imem_rvalid && !w_fifo_push) begin
            r_stat_squashed <= r_stat_squashed + 32'd1;
         end
      end
   end

   assign o_stat_fetched  = r_stat_fetched;
   assign o_stat_squashed = r_stat_squashed;
`endif

endmodule
